key_debounce: RTL and testbench

- Producer side of the push-button strobe (`str`) consumed by the team's counter/compare blocks.
- Takes a raw, asynchronous, bouncing mechanical key input and synchronises it to `clk`.
- Debounces it and emits a clean level, single-cycle press/release strobes and optional auto-repeat strobes while the key is held.
- Sits between the board pin and any block that expects one `str` pulse per physical press.

---
 rtl/key_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/key_debounce.sv | 147 ++++++++++++++
 tb/tb_key_debounce.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key debouncer and related board-input blocks.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    PRESSED    = 3'd2,
    HOLD       = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  // Width needed for a timer that counts up to max(cycle counts)-1.
  function automatic int calc_cnt_w(input int db, input int hold, input int rep);
    int m;
    m = db;
    if (hold > m) m = hold;
    if (rep > m) m = rep;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw mechanical key into a clean level plus press, release and
// auto-repeat strobes, all registered and one cycle wide.
module key_debounce
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = calc_cnt_w(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic str,
  output logic press_pulse,
  output logic release_pulse,
  output logic rpt_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] ZERO      = '0;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             key_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             str_reg, str_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             rpt_reg, rpt_next;
  logic             held_reg, held_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    str_next     = str_reg;
    held_next    = held_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    rpt_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_s) begin
          state_next = PRESS_DB;
          timer_next = ONE;
        end
      end
      PRESS_DB: begin
        if (!key_s) begin
          state_next = IDLE;
          timer_next = ZERO;
        end else if (timer_reg == DB_LAST) begin
          state_next = PRESSED;
          timer_next = ZERO;
          press_next = 1'b1;
          str_next   = 1'b1;
        end else begin
          timer_next = timer_reg + ONE;
        end
      end
      PRESSED: begin
        // Without auto-repeat the timer is parked at 0 so it can never wrap.
        if (!key_s) begin
          state_next = RELEASE_DB;
          timer_next = ONE;
        end else if (REPEAT_EN && timer_reg == HOLD_LAST) begin
          state_next = HOLD;
          timer_next = ZERO;
          rpt_next   = 1'b1;
          held_next  = 1'b1;
        end else if (REPEAT_EN) begin
          timer_next = timer_reg + ONE;
        end
      end
      HOLD: begin
        if (!key_s) begin
          state_next = RELEASE_DB;
          timer_next = ONE;
          held_next  = 1'b0;
        end else if (timer_reg == REP_LAST) begin
          timer_next = ZERO;
          rpt_next   = 1'b1;
        end else begin
          timer_next = timer_reg + ONE;
        end
      end
      RELEASE_DB: begin
        // A bounce back high restarts the hold delay but keeps str asserted.
        if (key_s) begin
          state_next = PRESSED;
          timer_next = ZERO;
        end else if (timer_reg == DB_LAST) begin
          state_next   = IDLE;
          timer_next   = ZERO;
          release_next = 1'b1;
          str_next     = 1'b0;
        end else begin
          timer_next = timer_reg + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = ZERO;
        str_next   = 1'b0;
        held_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= ZERO;
      str_reg     <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      rpt_reg     <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      str_reg     <= str_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      rpt_reg     <= rpt_next;
      held_reg    <= held_next;
    end
  end

  assign str           = str_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign rpt_pulse     = rpt_reg;
  assign held          = held_reg;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB=4, HOLD=16, REPEAT=8; edge n is the
// n-th rising edge after reset release, and key_in(n) is the value it samples.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b0;
  logic str, press_pulse, release_pulse, rpt_pulse, held;

  int compared = 0;
  int mismatched = 0;

  key_debounce #(
    .DB_CYCLES     (4),
    .HOLD_CYCLES   (16),
    .REPEAT_CYCLES (8),
    .REPEAT_EN     (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .str           (str),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .rpt_pulse     (rpt_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    key_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] g;
    rst = 1'b1;
    key_in = 1'b0;
    #3;
    g = {str, press_pulse, release_pulse, rpt_pulse, held};
    compared++;
    if (g !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_state: got %b expected 00000", g);
    end
    $display("test_reset: outputs %b during reset", g);
  endtask

  task automatic test_clean_press();
    logic [4:0] e, g;
    do_reset();
    for (int n = 1; n <= 25; n++) begin
      key_in = (n <= 12);
      @(posedge clk); #1;
      e = {(n >= 6 && n <= 17), n == 6, n == 18, 1'b0, 1'b0};
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL clean_press edge %0d: got %b expected %b", n, g, e);
      end
    end
    $display("test_clean_press: 25 edges checked");
  endtask

  task automatic test_press_bounce();
    logic [4:0] e, g;
    do_reset();
    for (int n = 1; n <= 18; n++) begin
      key_in = (n <= 3) || (n >= 5 && n <= 14);
      @(posedge clk); #1;
      e = {n >= 10, n == 10, 1'b0, 1'b0, 1'b0};
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL press_bounce edge %0d: got %b expected %b", n, g, e);
      end
    end
    $display("test_press_bounce: 18 edges checked");
  endtask

  task automatic test_glitch();
    logic [4:0] g;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      key_in = (n <= 3);
      @(posedge clk); #1;
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== 5'b0) begin
        mismatched++;
        $display("FAIL glitch edge %0d: got %b expected 00000", n, g);
      end
    end
    $display("test_glitch: 12 edges checked");
  endtask

  task automatic test_hold();
    logic [4:0] e, g;
    logic rpt_e;
    do_reset();
    for (int n = 1; n <= 60; n++) begin
      key_in = (n <= 50);
      @(posedge clk); #1;
      rpt_e = (n == 22) || (n == 30) || (n == 38) || (n == 46);
      e = {(n >= 6 && n <= 55), n == 6, n == 56, rpt_e, (n >= 22 && n <= 52)};
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL hold edge %0d: got %b expected %b", n, g, e);
      end
    end
    $display("test_hold: 60 edges checked");
  endtask

  task automatic test_release_bounce();
    logic [4:0] e, g;
    do_reset();
    for (int n = 1; n <= 36; n++) begin
      key_in = (n <= 10) || (n >= 13);
      @(posedge clk); #1;
      e = {n >= 6, n == 6, 1'b0, n == 31, n >= 31};
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL release_bounce edge %0d: got %b expected %b", n, g, e);
      end
    end
    $display("test_release_bounce: 36 edges checked");
  endtask

  task automatic test_reset_mid_op();
    logic [4:0] e, g;
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      key_in = 1'b1;
      @(posedge clk); #1;
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== 5'b0) begin
        mismatched++;
        $display("FAIL rst_phase_a edge %0d: got %b expected 00000", n, g);
      end
    end
    rst = 1'b1;
    #1;
    g = {str, press_pulse, release_pulse, rpt_pulse, held};
    compared++;
    if (g !== 5'b0) begin
      mismatched++;
      $display("FAIL rst_in_press_db: got %b expected 00000", g);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      e = {n >= 6, n == 6, 1'b0, n == 22, n >= 22};
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL rst_phase_b edge %0d: got %b expected %b", n, g, e);
      end
    end
    rst = 1'b1;
    #1;
    g = {str, press_pulse, release_pulse, rpt_pulse, held};
    compared++;
    if (g !== 5'b0) begin
      mismatched++;
      $display("FAIL rst_in_hold: got %b expected 00000", g);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      e = {n >= 6, n == 6, 1'b0, 1'b0, 1'b0};
      g = {str, press_pulse, release_pulse, rpt_pulse, held};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL rst_phase_c edge %0d: got %b expected %b", n, g, e);
      end
    end
    key_in = 1'b0;
    $display("test_reset_mid_op: reset in PRESS_DB and HOLD checked");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_glitch();
    test_hold();
    test_release_bounce();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
